// File: rtl/cmd_pulse_ctrl_if.sv
// ---------------------------------------------------------------------------
// cmd_pulse_ctrl_if
// Bundles the PS register bits and PL handshake signals of cmd_pulse_ctrl.
//
// Parameter
//   ARG_W           width of the command argument
//
// Signals
//   i_cmd_reg       PS register bit, 0->1 requests one command
//   i_cmd_arg       PS argument, captured when a request is accepted
//   i_clear_reg     PS register bit, 0->1 clears the sticky flags
//   i_done_pulse    PL one-cycle completion pulse
//   o_start_pulse   one-cycle command strobe to PL
//   o_cmd_arg       latched argument
//   o_busy          command outstanding
//   o_done_flag     sticky: command completed
//   o_drop_flag     sticky: request discarded while not idle
//   o_timeout_flag  sticky: command abandoned on timeout
//   o_cmd_cnt       count of accepted commands
//
// Modports
//   slave   the controller (drives the o_* signals)
//   master  the PS/PL side (drives the i_* signals)
// ---------------------------------------------------------------------------
interface cmd_pulse_ctrl_if #(
  parameter int ARG_W = 16
);
  logic             i_cmd_reg;
  logic [ARG_W-1:0] i_cmd_arg;
  logic             i_clear_reg;
  logic             i_done_pulse;
  logic             o_start_pulse;
  logic [ARG_W-1:0] o_cmd_arg;
  logic             o_busy;
  logic             o_done_flag;
  logic             o_drop_flag;
  logic             o_timeout_flag;
  logic [15:0]      o_cmd_cnt;

  modport slave (
    input  i_cmd_reg,
    input  i_cmd_arg,
    input  i_clear_reg,
    input  i_done_pulse,
    output o_start_pulse,
    output o_cmd_arg,
    output o_busy,
    output o_done_flag,
    output o_drop_flag,
    output o_timeout_flag,
    output o_cmd_cnt
  );

  modport master (
    output i_cmd_reg,
    output i_cmd_arg,
    output i_clear_reg,
    output i_done_pulse,
    input  o_start_pulse,
    input  o_cmd_arg,
    input  o_busy,
    input  o_done_flag,
    input  o_drop_flag,
    input  o_timeout_flag,
    input  o_cmd_cnt
  );
endinterface

// File: rtl/cmd_pulse_ctrl.sv
// ---------------------------------------------------------------------------
// cmd_pulse_ctrl
// Turns a PS register-bit rising edge into a single registered start strobe
// for PL logic, tracks the outstanding command until PL reports completion,
// and keeps sticky status flags plus an accepted-command counter.
//
// Parameters
//   ARG_W        width of the command argument
//   TIMEOUT_CYC  BUSY cycles allowed before the command is abandoned
//                (only meaningful when CMD_TIMEOUT_EN is defined)
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous, active-high reset
//   bus          cmd_pulse_ctrl_if.slave (see interface header for signals)
//
// Build option
//   CMD_TIMEOUT_EN  when defined, a BUSY-cycle counter abandons a command
//                   after TIMEOUT_CYC cycles and sets o_timeout_flag;
//                   when undefined, BUSY waits forever for i_done_pulse and
//                   o_timeout_flag is tied low.
// ---------------------------------------------------------------------------
module cmd_pulse_ctrl #(
  parameter int ARG_W       = 16,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic            clk,
  input  logic            rst,
  cmd_pulse_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  // ---------------------------------------------------------------------
  // Edge detection on the two PS register bits: bit 0 = cmd, bit 1 = clear.
  // The delay copies follow the inputs even during reset, so a level that
  // is already high when reset releases is not seen as a new edge.
  // ---------------------------------------------------------------------
  logic [1:0] lvl;
  logic [1:0] lvl_dly_reg;
  logic       req;
  logic       clr;

  assign lvl = {bus.i_clear_reg, bus.i_cmd_reg};
  assign req = lvl[0] & ~lvl_dly_reg[0];
  assign clr = lvl[1] & ~lvl_dly_reg[1];

  always_ff @(posedge clk) begin
    lvl_dly_reg <= lvl;
  end

  // ---------------------------------------------------------------------
  // Optional BUSY timeout
  // ---------------------------------------------------------------------
  logic tmo_expire;

`ifdef CMD_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TMO_W-1:0] tmo_cnt_reg;
  logic             tmo_set;
  logic             timeout_flag_reg;

  // BUSY is only ever entered from START, so clearing in START is the same
  // as clearing on entry to BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_reg <= '0;
    end else if (state_reg == ST_START) begin
      tmo_cnt_reg <= '0;
    end else if (state_reg == ST_BUSY) begin
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
  end

  assign tmo_expire = (state_reg == ST_BUSY) &&
                      (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC - 1));

  // A completion pulse on the expiry cycle takes priority over the timeout.
  assign tmo_set = tmo_expire & ~bus.i_done_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_flag_reg <= 1'b0;
    end else begin
      timeout_flag_reg <= tmo_set | (timeout_flag_reg & ~clr);
    end
  end

  assign bus.o_timeout_flag = timeout_flag_reg;
`else
  // Timeout logic not built: never expires, flag permanently low.
  assign tmo_expire         = (TIMEOUT_CYC < 1) & 1'b0;
  assign bus.o_timeout_flag = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req) begin
          state_next = ST_START;
        end
      end
      ST_START: begin
        state_next = ST_BUSY;
      end
      ST_BUSY: begin
        if (bus.i_done_pulse || tmo_expire) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: output logic. Produces the next values of every registered output
  // so that the strobe and busy lines come straight from flops.
  // ---------------------------------------------------------------------
  logic             start_pulse_reg;
  logic             start_pulse_next;
  logic             busy_reg;
  logic             busy_next;
  logic [ARG_W-1:0] cmd_arg_reg;
  logic [ARG_W-1:0] cmd_arg_next;
  logic [15:0]      cmd_cnt_reg;
  logic [15:0]      cmd_cnt_next;
  logic             done_flag_reg;
  logic             done_flag_next;
  logic             drop_flag_reg;
  logic             drop_flag_next;
  logic             accept;
  logic             drop_set;
  logic             done_set;

  always_comb begin
    accept   = (state_reg == ST_IDLE) && req;
    drop_set = (state_reg != ST_IDLE) && req;
    // Completion outside BUSY (IDLE or START) is deliberately ignored.
    done_set = (state_reg == ST_BUSY) && bus.i_done_pulse;

    start_pulse_next = (state_next == ST_START);
    busy_next        = (state_next != ST_IDLE);

    cmd_arg_next = cmd_arg_reg;
    cmd_cnt_next = cmd_cnt_reg;
    if (accept) begin
      cmd_arg_next = bus.i_cmd_arg;
      cmd_cnt_next = cmd_cnt_reg + 16'd1;  // wraps silently at 16'hFFFF
    end

    // Set has priority over a coincident clear edge.
    done_flag_next = done_set | (done_flag_reg & ~clr);
    drop_flag_next = drop_set | (drop_flag_reg & ~clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_pulse_reg <= 1'b0;
      busy_reg        <= 1'b0;
      cmd_arg_reg     <= '0;
      cmd_cnt_reg     <= 16'd0;
      done_flag_reg   <= 1'b0;
      drop_flag_reg   <= 1'b0;
    end else begin
      start_pulse_reg <= start_pulse_next;
      busy_reg        <= busy_next;
      cmd_arg_reg     <= cmd_arg_next;
      cmd_cnt_reg     <= cmd_cnt_next;
      done_flag_reg   <= done_flag_next;
      drop_flag_reg   <= drop_flag_next;
    end
  end

  assign bus.o_start_pulse = start_pulse_reg;
  assign bus.o_busy        = busy_reg;
  assign bus.o_cmd_arg     = cmd_arg_reg;
  assign bus.o_cmd_cnt     = cmd_cnt_reg;
  assign bus.o_done_flag   = done_flag_reg;
  assign bus.o_drop_flag   = drop_flag_reg;

endmodule

// File: tb/tb_cmd_pulse_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cmd_pulse_ctrl
// Scoreboard bench for cmd_pulse_ctrl. The stimulus process works at command
// level: for every command it computes, from the behavioural rules, the
// expected start record (argument, count) and completion record (busy
// length, sticky flags) and queues them. A monitor on the falling edge pops
// a start record on each start strobe and a completion record when busy
// drops. Reset, clear and idle-state checks are made directly.
// Build with +define+CMD_TIMEOUT_EN to exercise the timeout (TIMEOUT_CYC=8).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cmd_pulse_ctrl;
  localparam int ARG_W = 16;
  localparam int TMO   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cmd_pulse_ctrl_if #(.ARG_W(ARG_W)) bus ();

  cmd_pulse_ctrl #(
    .ARG_W      (ARG_W),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [15:0] arg;
    logic [15:0] cnt;
  } start_t;

  typedef struct {
    int blen;
    bit done;
    bit drop;
    bit tmo;
  } end_t;

  start_t start_q[$];
  end_t   end_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [15:0] m_cnt  = 16'd0;
  logic [15:0] m_arg  = 16'd0;
  bit          m_done = 1'b0;
  bit          m_drop = 1'b0;
  bit          m_tmo  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_start"}, 32'(bus.o_start_pulse), 0);
    chk({tag, "_busy"},  32'(bus.o_busy), 0);
    chk({tag, "_done"},  32'(bus.o_done_flag), 0);
    chk({tag, "_drop"},  32'(bus.o_drop_flag), 0);
    chk({tag, "_tmo"},   32'(bus.o_timeout_flag), 0);
    chk({tag, "_arg"},   32'(bus.o_cmd_arg), 0);
    chk({tag, "_cnt"},   32'(bus.o_cmd_cnt), 0);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_busy"}, 32'(bus.o_busy), 0);
    chk({tag, "_done"}, 32'(bus.o_done_flag), 32'(m_done));
    chk({tag, "_drop"}, 32'(bus.o_drop_flag), 32'(m_drop));
    chk({tag, "_tmo"},  32'(bus.o_timeout_flag), 32'(m_tmo));
    chk({tag, "_arg"},  32'(bus.o_cmd_arg), 32'(m_arg));
    chk({tag, "_cnt"},  32'(bus.o_cmd_cnt), 32'(m_cnt));
  endtask

  // ---------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------
  bit tracking = 1'b0;
  int blen     = 0;

  always @(negedge clk) begin
    start_t s;
    end_t   e;
    if (rst) begin
      tracking = 1'b0;
    end else begin
      if (bus.o_start_pulse === 1'b1) begin
        if (start_q.size() == 0) begin
          chk("unexpected_start", 32'(bus.o_start_pulse), 0);
        end else begin
          s = start_q.pop_front();
          chk("start_arg", 32'(bus.o_cmd_arg), 32'(s.arg));
          chk("start_cnt", 32'(bus.o_cmd_cnt), 32'(s.cnt));
        end
        tracking = 1'b1;
        blen     = 0;
      end
      if (tracking) begin
        if (bus.o_busy === 1'b1) begin
          blen++;
        end else begin
          tracking = 1'b0;
          if (end_q.size() == 0) begin
            chk("end_record_present", 32'(end_q.size()), 1);
          end else begin
            e = end_q.pop_front();
            chk("busy_len",  32'(blen), 32'(e.blen));
            chk("end_done",  32'(bus.o_done_flag), 32'(e.done));
            chk("end_drop",  32'(bus.o_drop_flag), 32'(e.drop));
            chk("end_tmo",   32'(bus.o_timeout_flag), 32'(e.tmo));
            $display("txn arg=%04h cnt=%04h busy=%0d done=%0b drop=%0b tmo=%0b",
                     bus.o_cmd_arg, bus.o_cmd_cnt, blen,
                     bus.o_done_flag, bus.o_drop_flag, bus.o_timeout_flag);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus
  //   d        negedges from the start strobe to the done pulse (>=1)
  //   tmode    0: no extra requests, 1: random toggles, 2: alternating
  //   dis      also pulse done during the START cycle (must be ignored)
  //   clr_done raise clear on the same cycle as done (no toggles allowed)
  // ---------------------------------------------------------------------
  task automatic run_cmd(input logic [15:0] arg, input int d, input int tmode,
                         input bit dis, input bit clr_done);
    bit     cmdv[0:15];
    int     lim;
    bit     done_ok;
    bit     any_drop;
    int     gap;
    start_t s;
    end_t   e;
`ifdef CMD_TIMEOUT_EN
    lim     = (d > TMO) ? TMO : d;
    done_ok = (d <= TMO);
`else
    lim     = d;
    done_ok = 1'b1;
`endif
    cmdv[0]  = 1'b0;
    cmdv[1]  = 1'b0;
    any_drop = 1'b0;
    for (int j = 2; j <= d + 1; j++) begin
      if (j <= lim + 1 && tmode == 1) cmdv[j] = 1'($urandom_range(0, 1));
      else if (j <= lim + 1 && tmode == 2) cmdv[j] = (j % 2 == 0);
      else cmdv[j] = cmdv[j-1];
      if (cmdv[j] && !cmdv[j-1]) any_drop = 1'b1;
    end

    m_cnt = m_cnt + 16'd1;
    m_arg = arg;
    s.arg = arg;
    s.cnt = m_cnt;
    start_q.push_back(s);
    if (clr_done) begin
      m_done = 1'b0;
      m_drop = 1'b0;
      m_tmo  = 1'b0;
    end
    if (any_drop) m_drop = 1'b1;
    if (done_ok) m_done = 1'b1;
    else m_tmo = 1'b1;
    e.blen = lim + 1;
    e.done = m_done;
    e.drop = m_drop;
    e.tmo  = m_tmo;
    end_q.push_back(e);

    @(negedge clk);
    bus.i_cmd_reg    = 1'b1;
    bus.i_cmd_arg    = arg;
    bus.i_done_pulse = 1'b0;
    @(negedge clk);
    bus.i_cmd_reg    = 1'b0;
    bus.i_done_pulse = dis;
    for (int j = 2; j <= d + 1; j++) begin
      @(negedge clk);
      bus.i_cmd_reg    = cmdv[j];
      bus.i_done_pulse = (j == d + 1);
      bus.i_clear_reg  = clr_done && (j == d + 1);
    end
    @(negedge clk);
    bus.i_cmd_reg    = 1'b0;
    bus.i_done_pulse = 1'b0;
    bus.i_clear_reg  = 1'b0;
    gap = int'($urandom_range(0, 3));
    repeat (gap) begin
      @(negedge clk);
      bus.i_done_pulse = 1'($urandom_range(0, 1));
    end
    bus.i_done_pulse = 1'b0;
  endtask

  task automatic do_clear(input string tag);
    @(negedge clk);
    bus.i_clear_reg = 1'b1;
    @(negedge clk);
    bus.i_clear_reg = 1'b0;
    m_done = 1'b0;
    m_drop = 1'b0;
    m_tmo  = 1'b0;
    chk_model(tag);
  endtask

  task automatic reset_in_busy();
    start_t s;
    m_cnt = m_cnt + 16'd1;
    s.arg = 16'hA5A5;
    s.cnt = m_cnt;
    start_q.push_back(s);
    @(negedge clk);
    bus.i_cmd_reg = 1'b1;
    bus.i_cmd_arg = 16'hA5A5;
    @(negedge clk);
    bus.i_cmd_reg = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.i_cmd_reg = 1'b1;
    m_cnt  = 16'd0;
    m_arg  = 16'd0;
    m_done = 1'b0;
    m_drop = 1'b0;
    m_tmo  = 1'b0;
    chk_zero("rst_busy");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_held_busy", 32'(bus.o_busy), 0);
    chk("rst_held_cnt",  32'(bus.o_cmd_cnt), 0);
    bus.i_cmd_reg = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int d;
    int tm;
    bit cd;
    bus.i_cmd_reg    = 1'b1;
    bus.i_cmd_arg    = 16'hBEEF;
    bus.i_clear_reg  = 1'b0;
    bus.i_done_pulse = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");

    // Request level held through reset release must not start a command.
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("held_cmd_busy", 32'(bus.o_busy), 0);
    chk("held_cmd_cnt",  32'(bus.o_cmd_cnt), 0);
    bus.i_cmd_reg = 1'b0;
    @(negedge clk);

    run_cmd(16'h1234, 5, 0, 1'b0, 1'b0);
    chk_model("basic");

    run_cmd(16'h5678, 6, 2, 1'b0, 1'b0);
    chk_model("drop");

    do_clear("clear");

    run_cmd(16'h9ABC, 4, 0, 1'b0, 1'b1);
    chk_model("clr_with_done");

    run_cmd(16'h0F0F, 3, 1, 1'b1, 1'b0);
    chk_model("done_in_start");

`ifdef CMD_TIMEOUT_EN
    do_clear("clear_pre_tmo");
    run_cmd(16'h7777, 12, 0, 1'b0, 1'b0);
    chk_model("timeout");
    do_clear("clear_post_tmo");
    run_cmd(16'h8888, TMO, 0, 1'b0, 1'b0);
    chk_model("done_on_expiry");
`endif

    // Counter wrap: preload the accepted-command count.
    @(negedge clk);
    force dut.cmd_cnt_reg = 16'hFFFF;
    @(negedge clk);
    release dut.cmd_cnt_reg;
    m_cnt = 16'hFFFF;
    run_cmd(16'hCAFE, 2, 0, 1'b0, 1'b0);
    chk_model("wrap");

    for (int i = 0; i < 120; i++) begin
      d  = int'($urandom_range(1, 12));
      tm = int'($urandom_range(0, 1));
      cd = (tm == 0) && (d <= TMO) && ($urandom_range(0, 3) == 0);
      run_cmd(16'($urandom), d, tm, 1'($urandom_range(0, 1)), cd);
      if (i % 10 == 9) do_clear("rand_clear");
    end

    reset_in_busy();
    run_cmd(16'h4321, 3, 0, 1'b0, 1'b0);
    chk_model("after_reset");

    repeat (5) @(negedge clk);
    chk("start_q_drained", 32'(start_q.size()), 0);
    chk("end_q_drained",   32'(end_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cmd_pulse_ctrl.md
CMD_PULSE_CTRL -- requirements
Module: cmd_pulse_ctrl

Interface
REQ-001 Parameter ARG_W, default 16: width of the command argument.
REQ-002 Parameter TIMEOUT_CYC, default 1000000: BUSY cycles allowed before timeout (used only with CMD_TIMEOUT_EN).
REQ-003 Timing and reset (already decided): one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 i_cmd_reg  in  1  PS register bit; a 0->1 transition requests one command.
REQ-007 i_cmd_arg  in  ARG_W  PS argument register, captured when a request is accepted.
REQ-008 i_clear_reg  in  1  PS register bit; a 0->1 transition clears the sticky flags.
REQ-009 i_done_pulse  in  1  PL one-cycle completion pulse.
REQ-010 o_start_pulse  out  1  one-cycle command strobe to PL.
REQ-011 o_cmd_arg  out  ARG_W  latched argument, stable from o_start_pulse until next accepted request.
REQ-012 o_busy  out  1  command outstanding.
REQ-013 o_done_flag  out  1  sticky: command completed.
REQ-014 o_drop_flag  out  1  sticky: request arrived while not IDLE and was discarded.
REQ-015 o_timeout_flag  out  1  sticky: command abandoned on timeout.
REQ-016 o_cmd_cnt  out  16  count of accepted commands.

Function
REQ-017 Edge detect: a request is i_cmd_reg==1 while its one-cycle-delayed copy ==0; i_clear_reg uses the same scheme.
REQ-018 FSM states: IDLE, START, BUSY.
- IDLE: request -> latch i_cmd_arg into o_cmd_arg, increment o_cmd_cnt, go to START.
- START: lasts one cycle, then go to BUSY.
- BUSY: i_done_pulse -> IDLE and set o_done_flag.
REQ-019 o_start_pulse is registered: high for exactly the START cycle, which begins one cycle after the edge where the request was sampled.
REQ-020 o_busy is high in START and BUSY, and low in IDLE.
REQ-021 A request sampled in START or BUSY is discarded: it sets o_drop_flag and leaves o_cmd_arg, o_cmd_cnt and the state unchanged.
REQ-022 i_done_pulse sampled in IDLE or START is ignored and sets no flag.
REQ-023 A clear edge zeroes o_done_flag, o_drop_flag and o_timeout_flag; if a set event occurs in the same cycle, the set wins.
REQ-024 o_cmd_cnt wraps from 16'hFFFF to 0 with no flag.
REQ-025 The clear edge has no effect on the FSM, o_cmd_cnt or o_cmd_arg.

Reset
REQ-026 While rst is high: state IDLE, all outputs 0, o_cmd_cnt 0, timeout counter 0.
REQ-027 While rst is high, both edge-detect delay registers load the current input values, so a level already high at reset release yields no request.
REQ-028 Reset in START or BUSY abandons the command and sets no flag.

Configuration
REQ-029 Macro CMD_TIMEOUT_EN defined: a counter clears on entry to BUSY and increments each BUSY cycle.
- When it reaches TIMEOUT_CYC-1 without i_done_pulse, the FSM returns to IDLE and sets o_timeout_flag.
- If i_done_pulse coincides with expiry, done wins: o_done_flag is set and o_timeout_flag is not.
REQ-030 Macro CMD_TIMEOUT_EN undefined: no counter is built, o_timeout_flag is tied to 0, and BUSY waits indefinitely for i_done_pulse.

Verification
REQ-031 Basic command: i_cmd_arg=16'h1234, raise i_cmd_reg, then i_done_pulse 5 cycles after the start pulse -> one-cycle o_start_pulse, o_cmd_arg=16'h1234, o_busy high 6 cycles, o_done_flag=1, o_cmd_cnt=1.
REQ-032 Request while busy: toggle i_cmd_reg 0->1->0->1 during BUSY -> o_drop_flag=1, o_cmd_cnt unchanged, no second o_start_pulse.
REQ-033 Flag clear: set o_done_flag and o_drop_flag, then raise i_clear_reg -> both 0 next cycle; clear edge coincident with i_done_pulse in BUSY -> o_done_flag=1.
REQ-034 Timeout (CMD_TIMEOUT_EN, TIMEOUT_CYC=8): no i_done_pulse -> o_timeout_flag=1 and o_busy=0 after 8 BUSY cycles; repeat with i_done_pulse on the expiry cycle -> o_done_flag=1, o_timeout_flag=0.
REQ-035 Reset behaviour: hold i_cmd_reg=1 through reset -> no o_start_pulse after release; assert rst during BUSY -> state IDLE, all outputs 0.
REQ-036 Counter wrap: preload 16'hFFFF accepted commands, issue one more request -> o_cmd_cnt=0.
